// File: rtl/cal_pkg.sv
// Shared calendar types and constants.
// Used by the date counter and its days-in-month helper.
package cal_pkg;

    localparam logic [3:0] JAN = 4'd1;
    localparam logic [3:0] FEB = 4'd2;
    localparam logic [3:0] MAR = 4'd3;
    localparam logic [3:0] APR = 4'd4;
    localparam logic [3:0] MAY = 4'd5;
    localparam logic [3:0] JUN = 4'd6;
    localparam logic [3:0] JUL = 4'd7;
    localparam logic [3:0] AUG = 4'd8;
    localparam logic [3:0] SEP = 4'd9;
    localparam logic [3:0] OCT = 4'd10;
    localparam logic [3:0] NOV = 4'd11;
    localparam logic [3:0] DEC = 4'd12;

    localparam logic [4:0] DAY_MAX  = 5'd31;
    localparam logic [6:0] YEAR_MAX = 7'd99;
    localparam logic [2:0] DOW_MAX  = 3'd6;

    typedef enum logic [1:0] {
        SEL_DAY   = 2'd0,
        SEL_MONTH = 2'd1,
        SEL_YEAR  = 2'd2,
        SEL_DOW   = 2'd3
    } sel_e;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET   = 2'd1,
        CLAMP = 2'd2
    } state_e;

endpackage

// File: rtl/cal_days_in_month.sv
// Days in a month for the 2000..2099 range.
// Shared by the increment and clamp paths.
module cal_days_in_month
    import cal_pkg::*;
(
    input  logic [3:0] month,
    input  logic       leap,
    output logic [4:0] dim
);

    // Month length lookup; February depends on leap
    always_comb begin
        dim = 5'd31;
        unique case (month)
            FEB:                dim = leap ? 5'd29 : 5'd28;
            APR, JUN, SEP, NOV: dim = 5'd30;
            JAN, MAR, MAY, JUL,
            AUG, OCT, DEC:      dim = 5'd31;
            default:            dim = 5'd31;
        endcase
    end

endmodule

// File: rtl/calendar_date_counter.sv
// Day/month/year/day-of-week counter driven by the day-rollover pulse.
// Field-set mode with range checks, post-set clamp and one pending increment.
module calendar_date_counter
    import cal_pkg::*;
#(
    parameter int SET_W     = 7,
    parameter int RESET_DOW = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             day_inc,
    input  logic             set_en,
    input  logic             set_stb,
    input  logic [1:0]       set_sel,
    input  logic [SET_W-1:0] set_data,
    output logic [4:0]       day,
    output logic [3:0]       month,
    output logic [6:0]       year,
    output logic [2:0]       dow,
    output logic             set_err,
    output logic             busy
);

    state_e     state_q, state_d;
    logic       pend_q, pend_d;
    logic [4:0] day_d, day_c, dim;
    logic [3:0] month_d;
    logic [6:0] year_d;
    logic [2:0] dow_d;
    logic       err_d;
    logic       inc;
    logic       leap;

    assign leap = (year[1:0] == 2'b00);

    cal_days_in_month u_dim (
        .month (month),
        .leap  (leap),
        .dim   (dim)
    );

    // Next-state, field writes, clamp and increment
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        day_d   = day;
        month_d = month;
        year_d  = year;
        dow_d   = dow;
        err_d   = 1'b0;
        inc     = 1'b0;
        day_c   = day;
        case (state_q)
            RUN: begin
                inc = day_inc;
                if (set_en)
                    state_d = SET;
            end
            SET: begin
                if (day_inc)
                    pend_d = 1'b1;
                if (set_en && set_stb) begin
                    unique case (sel_e'(set_sel))
                        SEL_DAY:
                            if (set_data != '0 &&
                                set_data <= SET_W'(DAY_MAX))
                                day_d = 5'(set_data);
                            else
                                err_d = 1'b1;
                        SEL_MONTH:
                            if (set_data != '0 &&
                                set_data <= SET_W'(DEC))
                                month_d = 4'(set_data);
                            else
                                err_d = 1'b1;
                        SEL_YEAR:
                            if (set_data <= SET_W'(YEAR_MAX))
                                year_d = 7'(set_data);
                            else
                                err_d = 1'b1;
                        SEL_DOW:
                            if (set_data <= SET_W'(DOW_MAX))
                                dow_d = 3'(set_data);
                            else
                                err_d = 1'b1;
                    endcase
                end
                if (!set_en)
                    state_d = CLAMP;
            end
            CLAMP: begin
                if (day > dim)
                    day_c = dim;
                day_d   = day_c;
                inc     = pend_q || day_inc;
                pend_d  = 1'b0;
                state_d = RUN;
            end
            default: state_d = RUN;
        endcase
        if (inc) begin
            dow_d = (dow == DOW_MAX) ? 3'd0 : dow + 3'd1;
            if (day_c < dim) begin
                day_d = day_c + 5'd1;
            end else if (month < DEC) begin
                day_d   = 5'd1;
                month_d = month + 4'd1;
            end else begin
                day_d   = 5'd1;
                month_d = JAN;
                year_d  = (year == YEAR_MAX) ? 7'd0 : year + 7'd1;
            end
        end
    end

    // State, fields and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pend_q  <= 1'b0;
            day     <= 5'd1;
            month   <= JAN;
            year    <= 7'd0;
            dow     <= 3'(RESET_DOW);
            set_err <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            day     <= day_d;
            month   <= month_d;
            year    <= year_d;
            dow     <= dow_d;
            set_err <= err_d;
            busy    <= (state_d != RUN);
        end
    end

endmodule
